// File: rtl/clint.sv
// Core-local interruptor for one hart: mtime, mtimecmp and msip registers,
// registered MTI/MSI levels, and a single-outstanding valid/ready slave port.
module clint #(
    parameter int TICK_DIV = 1,
    parameter int ADDR_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [7:0]        req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              mti,
    output logic              msi
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_accept;

    logic [PW-1:0] r_pre;
    logic [63:0]   r_mtime;
    logic [63:0]   r_mtimecmp;
    logic          r_msip;
    logic          r_mti;
    logic          r_msi;
    logic [63:0]   r_rdata;
    logic          r_err;

    logic          w_tick;
    logic          w_sel_msip;
    logic          w_sel_cmp;
    logic          w_sel_mtime;
    logic          w_err;
    logic          w_wr;
    logic [63:0]   w_rd_val;
    logic [63:0]   w_mtime_nxt;
    logic [63:0]   w_cmp_nxt;

    // Full-address compare also enforces 8-byte alignment of every mapped register.
    assign w_sel_msip  = (req_addr == ADDR_W'(16'h0000));
    assign w_sel_cmp   = (req_addr == ADDR_W'(16'h4000));
    assign w_sel_mtime = (req_addr == ADDR_W'(16'hBFF8));
    assign w_err       = !(w_sel_msip || w_sel_cmp || w_sel_mtime);
    assign w_wr        = w_accept && req_we && !w_err;
    assign w_tick      = (r_pre == PRE_LAST);

    // Read mux returns pre-update register values.
    always_comb begin
        w_rd_val = 64'd0;
        if (w_sel_msip)  w_rd_val = {63'd0, r_msip};
        if (w_sel_cmp)   w_rd_val = r_mtimecmp;
        if (w_sel_mtime) w_rd_val = r_mtime;
    end

    // Byte-merge writes; unwritten mtime bytes still take the tick increment.
    always_comb begin
        w_mtime_nxt = r_mtime + {63'd0, w_tick};
        w_cmp_nxt   = r_mtimecmp;
        for (int b = 0; b < 8; b++) begin
            if (w_wr && req_wstrb[b]) begin
                if (w_sel_mtime) w_mtime_nxt[8*b +: 8] = req_wdata[8*b +: 8];
                if (w_sel_cmp)   w_cmp_nxt[8*b +: 8]   = req_wdata[8*b +: 8];
            end
        end
    end

    // Handshake state register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Prescaler, timer registers, msip and interrupt levels.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pre      <= '0;
            r_mtime    <= 64'd0;
            r_mtimecmp <= '1;
            r_msip     <= 1'b0;
            r_mti      <= 1'b0;
            r_msi      <= 1'b0;
        end else begin
            r_pre      <= w_tick ? '0 : r_pre + 1'b1;
            r_mtime    <= w_mtime_nxt;
            r_mtimecmp <= w_cmp_nxt;
            if (w_wr && w_sel_msip && req_wstrb[0]) r_msip <= req_wdata[0];
            r_mti      <= (r_mtime >= r_mtimecmp);
            r_msi      <= r_msip;
        end
    end

    // Response payload is captured at accept and held through the response phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata <= 64'd0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= (req_we || w_err) ? 64'd0 : w_rd_val;
            r_err   <= w_err;
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign mti        = r_mti;
    assign msi        = r_msi;

endmodule

// File: tb/tb_clint.sv
module tb_clint;

    localparam int TD = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = 16'd0;
    logic [63:0] req_wdata = 64'd0;
    logic [7:0]  req_wstrb = 8'd0;
    logic        resp_ready = 1'b1;

    logic        req_ready, resp_valid, resp_err, mti, msi;
    logic [63:0] resp_rdata;
    logic        req_ready_d4, resp_valid_d4, resp_err_d4, mti_d4, msi_d4;
    logic [63:0] resp_rdata_d4;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    always #5 clock = ~clock;

    clint #(.TICK_DIV(TD), .ADDR_W(16)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mti(mti), .msi(msi)
    );

    clint #(.TICK_DIV(4), .ADDR_W(16)) u_dut_d4 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_d4), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid_d4), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_d4), .resp_err(resp_err_d4),
        .mti(mti_d4), .msi(msi_d4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: architectural registers plus a busy flag for the one-outstanding protocol.
    logic [63:0] m_mtime, m_cmp, m_rdata;
    logic        m_msip, m_busy, m_mti, m_msi, m_err;
    int          m_pre;

    always @(posedge clock) begin : model
        logic [63:0] nt, ncmp, rd;
        logic        nmsip, tick, e;
        if (reset) begin
            m_mtime <= 64'd0; m_cmp <= '1; m_msip <= 1'b0; m_pre <= 0;
            m_busy <= 1'b0; m_mti <= 1'b0; m_msi <= 1'b0;
            m_rdata <= 64'd0; m_err <= 1'b0;
        end else begin
            tick  = (m_pre == TD - 1);
            nt    = m_mtime + (tick ? 64'd1 : 64'd0);
            ncmp  = m_cmp;
            nmsip = m_msip;
            if (!m_busy && req_valid) begin
                e  = 1'b0;
                rd = 64'd0;
                case (req_addr)
                    16'h0000: rd = {63'd0, m_msip};
                    16'h4000: rd = m_cmp;
                    16'hBFF8: rd = m_mtime;
                    default:  e = 1'b1;
                endcase
                if (req_we) begin
                    rd = 64'd0;
                    for (int b = 0; b < 8; b++) begin
                        if (!e && req_wstrb[b]) begin
                            if (req_addr == 16'h0000 && b == 0) nmsip = req_wdata[0];
                            if (req_addr == 16'h4000) ncmp[8*b +: 8] = req_wdata[8*b +: 8];
                            if (req_addr == 16'hBFF8) nt[8*b +: 8]   = req_wdata[8*b +: 8];
                        end
                    end
                end
                m_rdata <= rd;
                m_err   <= e;
                m_busy  <= 1'b1;
            end else if (m_busy && resp_ready) begin
                m_busy <= 1'b0;
            end
            m_pre   <= tick ? 0 : m_pre + 1;
            m_mtime <= nt;
            m_cmp   <= ncmp;
            m_msip  <= nmsip;
            m_mti   <= (m_mtime >= m_cmp);
            m_msi   <= m_msip;
        end
    end

    // Every-cycle comparison of the visible outputs against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("resp_valid", {63'd0, resp_valid}, {63'd0, m_busy});
            chk("req_ready", {63'd0, req_ready}, {63'd0, !m_busy});
            chk("mti", {63'd0, mti}, {63'd0, m_mti});
            chk("msi", {63'd0, msi}, {63'd0, m_msi});
            if (m_busy) begin
                chk("rdata", resp_rdata, m_rdata);
                chk("err", {63'd0, resp_err}, {63'd0, m_err});
            end
        end
    end

    logic [63:0] rd, rd2;
    logic        er;

    // Called at a negedge; returns at the negedge after the response retires.
    task automatic xact(input logic we, input logic [15:0] addr, input logic [63:0] wd,
                        input logic [7:0] st, input int stall,
                        output logic [63:0] o_rd, output logic o_err, output logic [63:0] o_rd2);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = st;
        resp_ready = (stall == 0);
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) chk("accept_timeout", 64'd0, 64'd1);
        @(negedge clock);
        req_valid = 1'b0; req_we = 1'b0;
        o_rd = resp_rdata; o_err = resp_err; o_rd2 = resp_rdata_d4;
        for (int i = 0; i < stall; i++) begin
            chk("stall_valid", {63'd0, resp_valid}, 64'd1);
            chk("stall_rdata", resp_rdata, o_rd);
            chk("stall_ready", {63'd0, req_ready}, 64'd0);
            @(negedge clock);
        end
        resp_ready = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        logic [15:0] addrs [6];
        addrs[0] = 16'h0000; addrs[1] = 16'h4000; addrs[2] = 16'hBFF8;
        addrs[3] = 16'h4004; addrs[4] = 16'h1000; addrs[5] = 16'h0008;

        @(negedge clock);
        @(negedge clock);
        chk_en = 1'b1;
        reset = 1'b0;
        chk("rst_mti", {63'd0, mti}, 64'd0);
        chk("rst_msi", {63'd0, msi}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);

        // Tick rate: two mtime reads accepted 16 cycles apart.
        xact(1'b0, 16'hBFF8, 64'd0, 8'h00, 0, rd, er, rd2);
        chk("mtime0_div1", rd, 64'd0);
        chk("mtime0_div4", rd2, 64'd0);
        repeat (14) @(negedge clock);
        xact(1'b0, 16'hBFF8, 64'd0, 8'h00, 0, rd, er, rd2);
        chk("mtime16_div1", rd, 64'd16);
        chk("mtime16_div4", rd2, 64'd4);

        xact(1'b0, 16'h4000, 64'd0, 8'h00, 0, rd, er, rd2);
        chk("rst_cmp", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_cmp_err", {63'd0, er}, 64'd0);
        xact(1'b0, 16'h0000, 64'd0, 8'h00, 0, rd, er, rd2);
        chk("rst_msip", rd, 64'd0);

        // Reset while a write response is pending.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h4000; req_wdata = 64'd0;
        req_wstrb = 8'hFF; resp_ready = 1'b0;
        @(negedge clock);
        req_valid = 1'b0; req_we = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; resp_ready = 1'b1;
        chk("midrst_valid", {63'd0, resp_valid}, 64'd0);
        xact(1'b0, 16'h4000, 64'd0, 8'h00, 0, rd, er, rd2);
        chk("midrst_cmp", rd, 64'hFFFF_FFFF_FFFF_FFFF);

        // Timer compare rise and fall.
        repeat (2) @(negedge clock);
        xact(1'b1, 16'h4000, 64'd20, 8'hFF, 0, rd, er, rd2);
        begin
            int k = 0;
            while (!mti && k < 60) begin
                @(negedge clock);
                k++;
            end
        end
        chk("mti_rise", {63'd0, mti}, 64'd1);
        xact(1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, rd, er, rd2);
        chk("mti_fall", {63'd0, mti}, 64'd0);
        chk("wr_rdata", rd, 64'd0);

        // Software interrupt.
        xact(1'b1, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, rd, er, rd2);
        chk("msi_set", {63'd0, msi}, 64'd1);
        xact(1'b0, 16'h0000, 64'd0, 8'h00, 0, rd, er, rd2);
        chk("msip_rd", rd, 64'd1);
        xact(1'b1, 16'h0000, 64'd0, 8'hFF, 0, rd, er, rd2);
        chk("msi_clr", {63'd0, msi}, 64'd0);

        // mtime wrap with compare at zero.
        xact(1'b1, 16'h4000, 64'd0, 8'hFF, 0, rd, er, rd2);
        xact(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, rd, er, rd2);
        @(negedge clock);
        xact(1'b0, 16'hBFF8, 64'd0, 8'h00, 0, rd, er, rd2);
        chk("mtime_wrap", rd, 64'd0);
        chk("mti_wrap", {63'd0, mti}, 64'd1);

        // Upper-half byte strobe.
        xact(1'b1, 16'h4000, 64'h1111_1111_2222_2222, 8'hFF, 0, rd, er, rd2);
        xact(1'b1, 16'h4000, 64'hAAAA_AAAA_BBBB_BBBB, 8'hF0, 0, rd, er, rd2);
        xact(1'b0, 16'h4000, 64'd0, 8'h00, 0, rd, er, rd2);
        chk("strobe_hi", rd, 64'hAAAA_AAAA_2222_2222);

        // Unmapped and misaligned accesses.
        xact(1'b0, 16'h1000, 64'd0, 8'h00, 0, rd, er, rd2);
        chk("err_1000", {63'd0, er}, 64'd1);
        chk("err_1000_rd", rd, 64'd0);
        xact(1'b0, 16'h4004, 64'd0, 8'h00, 0, rd, er, rd2);
        chk("err_4004", {63'd0, er}, 64'd1);
        chk("err_4004_rd", rd, 64'd0);

        // Response back-pressure.
        xact(1'b0, 16'h4000, 64'd0, 8'h00, 3, rd, er, rd2);
        chk("stall_cmp", rd, 64'hAAAA_AAAA_2222_2222);

        // Randomized traffic checked by the per-cycle model compare.
        for (int t = 0; t < 60; t++) begin
            logic [15:0] a;
            logic [63:0] d;
            a = addrs[$urandom_range(0, 5)];
            d = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) d = d >> $urandom_range(40, 63);
            xact(1'($urandom_range(0, 1)), a, d, 8'($urandom), $urandom_range(0, 2), rd, er, rd2);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clint.md
Name: clint

Overview:
- Core-local interruptor for a single hart. Holds mtime, mtimecmp and msip, and generates the machine timer (MTI) and software (MSI) interrupt levels.
- Its mti/msi outputs drive the MTI/MSI fields of the hart_int bundle consumed by the CSR unit. The CSR unit samples them into mip.MTIP/mip.MSIP.
- Exposes a simple memory-mapped slave port with one-outstanding-request valid/ready handshake on both the request and response channels.

Parameters:
- TICK_DIV, 1, clock cycles per mtime increment (>=1); 1 = increment every cycle.
- ADDR_W, 16, request address width; offsets are relative to the CLINT base.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte offset
- req_wdata  in  64  write data
- req_wstrb  in  8  byte write enables
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed when valid&ready
- resp_rdata  out  64  read data (0 for writes/errors)
- resp_err  out  1  access error
- mti  out  1  timer interrupt pending level
- msi  out  1  software interrupt pending level

Behaviour:
- Clock is clock; reset is reset, synchronous, active-high.
- Reset values:
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0, prescaler = 0.
  - FSM = IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0, mti = 0, msi = 0.
  - Reset mid-transaction drops the pending response with no register effect beyond the reset values.
- Register map (decode on req_addr[ADDR_W-1:3]; req_addr[2:0] must be 0, else error):
  - 0x0000 MSIP: bit0 R/W, bits 63:1 read 0 and ignore writes.
  - 0x4000 MTIMECMP: 64-bit R/W.
  - 0xBFF8 MTIME: 64-bit R/W.
  - All other offsets: resp_err = 1, rdata = 0, no side effect.
- Byte strobes: a write updates only the bytes whose wstrb bit is set. Writing wstrb=8'h0F or 8'hF0 updates a 32-bit half. wstrb=0 is a legal no-op write.
- FSM states IDLE and RESP:
  - IDLE: req_ready = 1. On req_valid, accept the request, perform the register write (if any) at that edge, latch rdata/err, and go to RESP.
  - RESP: req_ready = 0, resp_valid = 1, and rdata/err are held stable. On resp_ready, go to IDLE.
  - A back-to-back accept in the same cycle the response retires is not allowed; minimum 2 cycles per transaction.
- Read data is the register value before any same-edge update, i.e. the mtime value in the accept cycle.
- Write responses return rdata = 0, err = 0 when mapped.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps; tick asserts when count == TICK_DIV-1.
  - On tick, mtime <= mtime + 1, wrapping 2^64-1 -> 0.
  - A software write to mtime bytes takes priority over the tick increment in the same cycle. Bytes not written still receive that cycle's increment value. The prescaler is unaffected by mtime writes.
- Interrupt outputs:
  - mti is registered: mti <= (mtime >= mtimecmp), unsigned compare on current register values, so it lags a register change by 1 cycle.
  - msi <= msip, also 1 cycle after the write edge.
  - Both outputs are levels. mti deasserts only when mtimecmp is raised above mtime or mtime is written below mtimecmp.

Test Plan:
- Reset, then read MTIMECMP and MSIP → rdata 64'hFFFF_FFFF_FFFF_FFFF and 0, err = 0; mti = 0, msi = 0.
- TICK_DIV=1: write MTIMECMP=20 at cycle 5 after reset, hold → mti rises the cycle after mtime reaches 20. Then write MTIMECMP=64'hFFFF_FFFF_FFFF_FFFF → mti falls 1 cycle after the write edge.
- Write MSIP=64'hFFFF_FFFF_FFFF_FFFF → msi = 1 next cycle and readback = 1. Write 0 → msi = 0 next cycle.
- Write MTIME=64'hFFFF_FFFF_FFFF_FFFE, wait 2 ticks → mtime reads 0 (wrap); with MTIMECMP=0, mti stays 1.
- Byte strobe: MTIMECMP=64'h1111_1111_2222_2222, write 64'hAAAA_AAAA_BBBB_BBBB with wstrb=8'hF0 → reads 64'hAAAA_AAAA_2222_2222.
- Read 0x1000 and read 0x4004 → err = 1, rdata = 0. Hold resp_ready=0 for 3 cycles → resp_valid/rdata stable and req_ready = 0 throughout. TICK_DIV=4 → mtime increments every 4 cycles.
